ex_div_seq: RTL and testbench
=============================

// Module: ex_div_seq
// PURPOSE
//  Multi-cycle divide sequencer beside the EX-stage ALU. It latches operands on a start
//  request and runs a restoring divide at one quotient bit per cycle. It holds the pipeline
//  through stall_req_o until the quotient and remainder are ready, then delivers them to the
//  EX result mux for a single cycle. Handles signed/unsigned, divide-by-zero and cancel (flush).
// PARAMETERS
//  WIDTH   16   operand/result width (matches RegBus)
// PORTS
//  clk             in   1      system clock, all state on rising edge
//  rst             in   1      synchronous reset, active-low (rst==0 resets on clk edge)
//  start_i         in   1      EX holds a divide op; sampled only in IDLE
//  signed_i        in   1      1 = two's-complement divide, 0 = unsigned
//  dividend_i      in   WIDTH  operand1 from ID/EX
//  divisor_i       in   WIDTH  operand2 from ID/EX
//  cancel_i        in   1      pipeline flush; aborts any operation
//  stall_req_o     out  1      request to freeze IF/ID/EX while dividing
//  busy_o          out  1      1 in any state other than IDLE
//  result_valid_o  out  1      one-cycle pulse: quotient_o/remainder_o valid
//  quotient_o      out  WIDTH  quotient, held until next start
//  remainder_o     out  WIDTH  remainder, held until next start
//  div_zero_o      out  1      qualifies result_valid_o: divisor was zero
// BEHAVIOUR
//  - States: IDLE, ZERO, RUN, DONE. Reset (rst==0): state=IDLE, count=0, all outputs 0.
//  - Reset and cancel_i both win over everything in any state: next state IDLE, no valid pulse.
//  - IDLE: start_i&!cancel_i latches signed_i, |dividend|, |divisor|, and the result signs.
//    |x| = -x if signed_i & x[WIDTH-1], else x. The quotient sign is the XOR of the operand
//    signs; the remainder sign is the dividend sign.
//    Next state is ZERO if divisor_i==0, else RUN with count=0.
//  - RUN: each cycle shifts {rem,quo} left by 1, subtracts divisor from the upper half (WIDTH+1-bit
//    compare), sets quo LSB on no-borrow; count++. At count==WIDTH-1, next state is DONE.
//  - ZERO: one cycle; quotient = all ones, remainder = raw dividend; next DONE, div_zero_o=1.
//  - DONE: result_valid_o=1 for exactly this cycle, then IDLE unconditionally. start_i is
//    ignored in DONE and is accepted on a later IDLE cycle. The signs are applied on entry
//    to DONE, and quotient_o/remainder_o are registered by the DONE cycle.
//  - stall_req_o (combinational) = (IDLE & start_i & !cancel_i) | RUN | ZERO; 0 in DONE, so EX
//    advances in the same cycle the result is valid.
//  - Latency: start accepted at cycle 0 -> result_valid_o at cycle WIDTH+1 (normal),
//    cycle 2 (divide by zero). Throughput one divide per WIDTH+2 cycles.
//  - Operands are sampled only at acceptance; later changes on dividend_i/divisor_i ignored.
//  - Signed overflow -2^(WIDTH-1) / -1: quotient = 0x8000 (wraps), remainder = 0, no flag.
//  - quotient_o/remainder_o/div_zero_o hold their last values between operations.
//    They are not cleared by cancel; they are cleared only by reset.
// TESTING
//  - Unsigned 100/7, signed_i=0 -> stall for 17 cycles, pulse at cycle 17: q=14, r=2.
//  - Signed -7/2 (0xFFF9/0x0002) -> q=0xFFFD (-3), r=0xFFFF (-1). The same operands unsigned
//    give q=0x7FFC, r=1.
//  - Divisor 0, dividend 0x1234 -> pulse at cycle 2, div_zero_o=1, q=0xFFFF, r=0x1234.
//  - Signed 0x8000/0xFFFF -> q=0x8000, r=0; 0x0005/0x0009 unsigned -> q=0, r=5.
//  - cancel_i at RUN count=5 -> IDLE next cycle, stall_req_o=0, no result_valid_o. Repeat
//    with rst=0 mid-RUN -> all outputs 0.
//  - start_i held high through DONE -> no restart in DONE; new op accepted the following
//    IDLE cycle with correct result.

Source files
------------

// File: rtl/ex_div_seq_if.sv
// Handshake and result bundle between the EX stage and the multi-cycle divide sequencer.
// The master side is the EX stage issuing divides; the slave side is the sequencer.
interface ex_div_seq_if #(
    parameter int unsigned WIDTH = 16
);
    logic             start_i;
    logic             signed_i;
    logic [WIDTH-1:0] dividend_i;
    logic [WIDTH-1:0] divisor_i;
    logic             cancel_i;
    logic             stall_req_o;
    logic             busy_o;
    logic             result_valid_o;
    logic [WIDTH-1:0] quotient_o;
    logic [WIDTH-1:0] remainder_o;
    logic             div_zero_o;

    modport master (
        output start_i,
        output signed_i,
        output dividend_i,
        output divisor_i,
        output cancel_i,
        input  stall_req_o,
        input  busy_o,
        input  result_valid_o,
        input  quotient_o,
        input  remainder_o,
        input  div_zero_o
    );

    modport slave (
        input  start_i,
        input  signed_i,
        input  dividend_i,
        input  divisor_i,
        input  cancel_i,
        output stall_req_o,
        output busy_o,
        output result_valid_o,
        output quotient_o,
        output remainder_o,
        output div_zero_o
    );
endinterface

// File: rtl/ex_div_seq.sv
// Multi-cycle restoring divider beside the EX-stage ALU. One quotient bit per cycle,
// stalls the pipeline while running and presents quotient/remainder for one cycle.
module ex_div_seq #(
    parameter int unsigned WIDTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    ex_div_seq_if.slave  bus
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {StIdle, StZero, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    // quo_q holds the shifting dividend/quotient; in the zero path it keeps the raw dividend
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             div_zero_q, div_zero_d;

    logic             dd_neg, dv_neg;
    logic [WIDTH-1:0] dd_abs, dv_abs;
    logic [WIDTH:0]   rem_sh, diff;
    logic             no_borrow;
    logic [WIDTH-1:0] rem_step, quo_step;
    logic             accept;

    // Operand magnitudes and signs as seen at acceptance
    always_comb begin
        dd_neg = bus.signed_i & bus.dividend_i[WIDTH-1];
        dv_neg = bus.signed_i & bus.divisor_i[WIDTH-1];
        dd_abs = dd_neg ? -bus.dividend_i : bus.dividend_i;
        dv_abs = dv_neg ? -bus.divisor_i : bus.divisor_i;
    end

    // One restoring step: shift {rem,quo} left, trial-subtract divisor on WIDTH+1 bits
    always_comb begin
        rem_sh    = {rem_q, quo_q[WIDTH-1]};
        diff      = rem_sh - {1'b0, dvs_q};
        no_borrow = ~diff[WIDTH];
        rem_step  = no_borrow ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        quo_step  = {quo_q[WIDTH-2:0], no_borrow};
    end

    assign accept = (state_q == StIdle) & bus.start_i & ~bus.cancel_i;

    // Next-state and datapath updates; cancel aborts without touching the result registers
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        quo_d       = quo_q;
        rem_d       = rem_q;
        dvs_d       = dvs_q;
        q_neg_d     = q_neg_q;
        r_neg_d     = r_neg_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        div_zero_d  = div_zero_q;

        if (bus.cancel_i) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.start_i) begin
                        q_neg_d = dd_neg ^ dv_neg;
                        r_neg_d = dd_neg;
                        dvs_d   = dv_abs;
                        rem_d   = '0;
                        cnt_d   = '0;
                        if (bus.divisor_i == '0) begin
                            quo_d   = bus.dividend_i;
                            state_d = StZero;
                        end else begin
                            quo_d   = dd_abs;
                            state_d = StRun;
                        end
                    end
                end
                StRun: begin
                    quo_d = quo_step;
                    rem_d = rem_step;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CntW'(WIDTH - 1)) begin
                        // Last bit: apply signs and register the result as DONE is entered
                        cnt_d       = '0;
                        state_d     = StDone;
                        quotient_d  = q_neg_q ? -quo_step : quo_step;
                        remainder_d = r_neg_q ? -rem_step : rem_step;
                        div_zero_d  = 1'b0;
                    end
                end
                StZero: begin
                    quotient_d  = '1;
                    remainder_d = quo_q;
                    div_zero_d  = 1'b1;
                    state_d     = StDone;
                end
                StDone: begin
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and result registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q       <= '0;
            quo_q       <= '0;
            rem_q       <= '0;
            dvs_q       <= '0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            div_zero_q  <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            quo_q       <= quo_d;
            rem_q       <= rem_d;
            dvs_q       <= dvs_d;
            q_neg_q     <= q_neg_d;
            r_neg_q     <= r_neg_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            div_zero_q  <= div_zero_d;
        end
    end

    // Stall drops in DONE so EX advances in the same cycle the result is valid
    assign bus.stall_req_o    = accept | (state_q == StRun) | (state_q == StZero);
    assign bus.busy_o         = (state_q != StIdle);
    assign bus.result_valid_o = (state_q == StDone) & rst & ~bus.cancel_i;
    assign bus.quotient_o     = quotient_q;
    assign bus.remainder_o    = remainder_q;
    assign bus.div_zero_o     = div_zero_q;

endmodule

// File: tb/tb_ex_div_seq.sv
// Self-checking bench for ex_div_seq: directed and random divides against an arithmetic model.
module tb_ex_div_seq;

    localparam int unsigned W = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    ex_div_seq_if #(.WIDTH(W)) bus ();

    ex_div_seq #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int nvec = 0;
    int nerr = 0;

    logic [W-1:0] last_q = '0;
    logic [W-1:0] last_r = '0;
    logic         last_z = 1'b0;

    // Reference: plain integer division (C-style truncation toward zero)
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic sgn, output logic [W-1:0] q,
                                  output logic [W-1:0] r, output logic z);
        int sa;
        int sb;
        if (b == '0) begin
            q = '1;
            r = a;
            z = 1'b1;
        end else if (sgn) begin
            sa = $signed(a);
            sb = $signed(b);
            q  = W'(sa / sb);
            r  = W'(sa % sb);
            z  = 1'b0;
        end else begin
            q = a / b;
            r = a % b;
            z = 1'b0;
        end
    endfunction

    // Issue one divide; operands on later cycles are na/nb/nsgn; keep leaves start_i high
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                          input logic [W-1:0] na, input logic [W-1:0] nb, input logic nsgn,
                          input logic keep, input string name);
        logic [W-1:0] eq;
        logic [W-1:0] er;
        logic         ez;
        int           lat;
        int           exp_lat;
        model(a, b, sgn, eq, er, ez);
        exp_lat = (b == '0) ? 2 : W + 1;
        @(posedge clk); #1;
        bus.start_i    = 1'b1;
        bus.signed_i   = sgn;
        bus.dividend_i = a;
        bus.divisor_i  = b;
        @(negedge clk);
        nvec++;
        if (bus.stall_req_o !== 1'b1 || bus.busy_o !== 1'b0) begin
            nerr++;
            $display("FAIL %s accept: stall=%b busy=%b, required stall=1 busy=0",
                     name, bus.stall_req_o, bus.busy_o);
        end
        lat = 0;
        for (int c = 1; c <= int'(W) + 4; c++) begin
            @(posedge clk); #1;
            bus.start_i    = keep;
            bus.signed_i   = nsgn;
            bus.dividend_i = na;
            bus.divisor_i  = nb;
            @(negedge clk);
            if (bus.result_valid_o === 1'b1) begin
                lat = c;
                break;
            end
            nvec++;
            if (bus.stall_req_o !== 1'b1) begin
                nerr++;
                $display("FAIL %s stall@%0d: got %b, required 1", name, c, bus.stall_req_o);
            end
        end
        nvec++;
        if (lat != exp_lat) begin
            nerr++;
            $display("FAIL %s latency: got %0d, required %0d", name, lat, exp_lat);
        end
        if (lat != 0) begin
            nvec++;
            if (bus.quotient_o !== eq || bus.remainder_o !== er || bus.div_zero_o !== ez ||
                bus.stall_req_o !== 1'b0) begin
                nerr++;
                $display("FAIL %s result: q=%h r=%h z=%b stall=%b, required q=%h r=%h z=%b stall=0",
                         name, bus.quotient_o, bus.remainder_o, bus.div_zero_o,
                         bus.stall_req_o, eq, er, ez);
            end
        end
        last_q = eq;
        last_r = er;
        last_z = ez;
        if (!keep) begin
            @(posedge clk); #1;
            bus.start_i = 1'b0;
            @(negedge clk);
            nvec++;
            if (bus.busy_o !== 1'b0 || bus.result_valid_o !== 1'b0 ||
                bus.quotient_o !== eq || bus.remainder_o !== er) begin
                nerr++;
                $display("FAIL %s hold: busy=%b valid=%b q=%h r=%h, required 0 0 q=%h r=%h",
                         name, bus.busy_o, bus.result_valid_o, bus.quotient_o,
                         bus.remainder_o, eq, er);
            end
        end
    endtask

    task automatic test_reset();
        rst            = 1'b0;
        bus.start_i    = 1'b0;
        bus.signed_i   = 1'b0;
        bus.dividend_i = '0;
        bus.divisor_i  = '0;
        bus.cancel_i   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        nvec++;
        if ({bus.stall_req_o, bus.busy_o, bus.result_valid_o, bus.div_zero_o} !== 4'b0 ||
            bus.quotient_o !== '0 || bus.remainder_o !== '0) begin
            nerr++;
            $display("FAIL reset: stall=%b busy=%b valid=%b z=%b q=%h r=%h, required all 0",
                     bus.stall_req_o, bus.busy_o, bus.result_valid_o, bus.div_zero_o,
                     bus.quotient_o, bus.remainder_o);
        end
        rst = 1'b1;
    endtask

    task automatic test_directed();
        run_op(16'd100, 16'd7, 1'b0, 16'hAAAA, 16'h0003, 1'b1, 1'b0, "u100_7");
        run_op(16'hFFF9, 16'h0002, 1'b1, 16'h1111, 16'h0000, 1'b0, 1'b0, "s-7_2");
        run_op(16'hFFF9, 16'h0002, 1'b0, 16'h2222, 16'h0005, 1'b1, 1'b0, "u_fff9_2");
        run_op(16'h1234, 16'h0000, 1'b0, 16'h5555, 16'h0001, 1'b0, 1'b0, "divzero");
        run_op(16'h8000, 16'hFFFF, 1'b1, 16'h0001, 16'h0001, 1'b0, 1'b0, "s_ovf");
        run_op(16'h0005, 16'h0009, 1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, "u5_9");
        run_op(16'hFFF9, 16'h0000, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, "s_divzero");
        run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, "u_max_1");
    endtask

    task automatic test_random();
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;
        for (int i = 0; i < 30; i++) begin
            a = W'($urandom);
            b = ($urandom_range(7) == 0) ? '0 : W'($urandom >> $urandom_range(15));
            s = 1'($urandom);
            run_op(a, b, s, W'($urandom), W'($urandom), 1'($urandom), 1'b0, "random");
        end
    endtask

    task automatic test_back_to_back();
        // start_i stays high through DONE; second op must start only on the next IDLE cycle
        run_op(16'd1000, 16'd33, 1'b0, 16'hFF00, 16'h0010, 1'b1, 1'b1, "b2b_first");
        run_op(16'hFF00, 16'h0010, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, "b2b_second");
    endtask

    task automatic test_cancel();
        int seen;
        @(posedge clk); #1;
        bus.start_i    = 1'b1;
        bus.signed_i   = 1'b0;
        bus.dividend_i = 16'd1000;
        bus.divisor_i  = 16'd3;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk); #1;
            bus.start_i = 1'b0;
            if (c == 6) bus.cancel_i = 1'b1;
        end
        @(negedge clk);
        nvec++;
        if (bus.stall_req_o !== 1'b1 || bus.result_valid_o !== 1'b0) begin
            nerr++;
            $display("FAIL cancel_cycle: stall=%b valid=%b, required 1 0",
                     bus.stall_req_o, bus.result_valid_o);
        end
        @(posedge clk); #1;
        bus.cancel_i = 1'b0;
        @(negedge clk);
        nvec++;
        if (bus.stall_req_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.result_valid_o !== 1'b0 ||
            bus.quotient_o !== last_q || bus.remainder_o !== last_r ||
            bus.div_zero_o !== last_z) begin
            nerr++;
            $display("FAIL cancel_after: stall=%b busy=%b valid=%b q=%h r=%h z=%b, required 0 0 0 q=%h r=%h z=%b",
                     bus.stall_req_o, bus.busy_o, bus.result_valid_o, bus.quotient_o,
                     bus.remainder_o, bus.div_zero_o, last_q, last_r, last_z);
        end
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.result_valid_o !== 1'b0 || bus.busy_o !== 1'b0) seen++;
        end
        nvec++;
        if (seen != 0) begin
            nerr++;
            $display("FAIL cancel_quiet: got %0d active cycles, required 0", seen);
        end
        run_op(16'd1000, 16'd3, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, "after_cancel");
    endtask

    task automatic test_reset_mid_run();
        @(posedge clk); #1;
        bus.start_i    = 1'b1;
        bus.signed_i   = 1'b1;
        bus.dividend_i = 16'hF000;
        bus.divisor_i  = 16'h0007;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk); #1;
            bus.start_i = 1'b0;
            if (c == 6) rst = 1'b0;
        end
        @(posedge clk); #1;
        @(negedge clk);
        nvec++;
        if ({bus.stall_req_o, bus.busy_o, bus.result_valid_o, bus.div_zero_o} !== 4'b0 ||
            bus.quotient_o !== '0 || bus.remainder_o !== '0) begin
            nerr++;
            $display("FAIL reset_mid_run: stall=%b busy=%b valid=%b z=%b q=%h r=%h, required all 0",
                     bus.stall_req_o, bus.busy_o, bus.result_valid_o, bus.div_zero_o,
                     bus.quotient_o, bus.remainder_o);
        end
        rst = 1'b1;
        run_op(16'hF000, 16'h0007, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, "after_reset");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_cancel();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
